alu_op_sequencer: RTL and testbench

//  Drives the combinational ALU: accepts ops over valid/ready, holds the accumulator (AC),

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_op_sequencer_if.sv | 35 +++
 rtl/alu_settle_cnt.sv | 34 +++
 rtl/alu_op_sequencer.sv | 140 ++++++++++++++
 tb/tb_alu_op_sequencer.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_pkg : opcodes, op width and sequencer FSM encoding shared     |
// |           by the ALU and alu_op_sequencer.                        |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package alu_pkg;

  localparam int ALU_W_DEF = 16;
  localparam int OP_W      = 4;

  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_NOT  = 4'h3,
    OP_AND  = 4'h4,
    OP_OR   = 4'h5,
    OP_XOR  = 4'h6,
    OP_MUL  = 4'h7,
    OP_SHR1 = 4'h8,
    OP_SHR2 = 4'h9,
    OP_MOV  = 4'hA,
    OP_CLR  = 4'hB
  } opcode_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_op_sequencer_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_op_sequencer_if : op handshake, ALU bus and architectural     |
// |                       state outputs of the sequencer.             |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
interface alu_op_sequencer_if #(
  parameter int W = 16
);
  logic          op_valid;
  logic [3:0]    op_code;
  logic [W-1:0]  op_operand;
  logic          op_ready;
  logic [3:0]    alu_cs;
  logic [W-1:0]  alu_acin;
  logic [W-1:0]  alu_rin;
  logic [W-1:0]  alu_acout;
  logic          alu_z;
  logic [W-1:0]  ac_q;
  logic          z_q;
  logic          done;
  logic          illegal;
  logic [15:0]   op_count;

  modport slave (
    input  op_valid, op_code, op_operand, alu_acout, alu_z,
    output op_ready, alu_cs, alu_acin, alu_rin, ac_q, z_q, done, illegal, op_count
  );

  modport master (
    output op_valid, op_code, op_operand, alu_acout, alu_z,
    input  op_ready, alu_cs, alu_acin, alu_rin, ac_q, z_q, done, illegal, op_count
  );
endinterface
`default_nettype wire

// File: rtl/alu_settle_cnt.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_settle_cnt : loadable down-counter flagging the final settle  |
// |                  cycle of an issued ALU op.                       |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module alu_settle_cnt #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_last
);

  logic [CNT_W-1:0] r_cnt;

  assign o_last = (r_cnt == CNT_W'(1));

  // Holds at 1 so a stray decrement can never wrap to the maximum count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && !o_last) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_op_sequencer : accepts ALU ops, holds operands for a settle   |
// |   time, commits result to AC/Z. Optional ZCHECK_EN adds a sticky  |
// |   z_mismatch output comparing ALU zero flag with the local one.   |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int W          = ALU_W_DEF,
  parameter int SETTLE     = 1,
  parameter int MUL_SETTLE = 2
) (
  input  logic clk,
  input  logic reset_n,
`ifdef ZCHECK_EN
  output logic z_mismatch,
`endif
  alu_op_sequencer_if.slave bus
);

  localparam int MAX_SETTLE = (SETTLE > MUL_SETTLE) ? SETTLE : MUL_SETTLE;
  localparam int CNT_W      = $clog2(MAX_SETTLE + 1);

  state_t           r_state;
  state_t           w_next;
  logic [OP_W-1:0]  r_code;
  logic [W-1:0]     r_operand;
  logic [W-1:0]     r_ac;
  logic             r_z;
  logic             r_done;
  logic             r_illegal;
  logic [15:0]      r_count;

  logic             w_idle;
  logic             w_busy;
  logic             w_accept;
  logic             w_illegal_op;
  logic             w_issue;
  logic             w_cnt_last;
  logic             w_res_zero;
  logic [CNT_W-1:0] w_load_val;

  assign w_idle       = (r_state == ST_IDLE);
  assign w_busy       = (r_state == ST_ISSUE) || (r_state == ST_COMMIT);
  assign w_accept     = w_idle && bus.op_valid;
  assign w_illegal_op = (bus.op_code > OP_CLR);
  assign w_issue      = w_accept && !w_illegal_op;
  assign w_res_zero   = (bus.alu_acout == '0);
  assign w_load_val   = (bus.op_code == OP_MUL) ? CNT_W'(MUL_SETTLE) : CNT_W'(SETTLE);

  assign bus.op_ready = w_idle;
  assign bus.alu_cs   = w_busy ? r_code : OP_NOP;
  assign bus.alu_acin = r_ac;
  assign bus.alu_rin  = r_operand;
  assign bus.ac_q     = r_ac;
  assign bus.z_q      = r_z;
  assign bus.done     = r_done;
  assign bus.illegal  = r_illegal;
  assign bus.op_count = r_count;

  alu_settle_cnt #(
    .CNT_W (CNT_W)
  ) u_settle (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_issue),
    .i_load_val (w_load_val),
    .i_dec      (r_state == ST_ISSUE),
    .o_last     (w_cnt_last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:   if (w_issue) w_next = ST_ISSUE;
      ST_ISSUE:  if (w_cnt_last) w_next = ST_COMMIT;
      ST_COMMIT: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Rejected ops never leave IDLE; their done/illegal pulse comes straight from the accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_code    <= OP_NOP;
      r_operand <= '0;
      r_ac      <= '0;
      r_z       <= 1'b0;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      r_count   <= '0;
    end else begin
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      if (w_accept) begin
        r_code    <= bus.op_code;
        r_operand <= bus.op_operand;
        if (w_illegal_op) begin
          r_done    <= 1'b1;
          r_illegal <= 1'b1;
        end
      end
      if (r_state == ST_COMMIT) begin
        r_ac    <= bus.alu_acout;
        r_z     <= w_res_zero;
        r_done  <= 1'b1;
        r_count <= r_count + 16'd1;
      end
    end
  end

`ifdef ZCHECK_EN
  logic r_zmis;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_zmis <= 1'b0;
    end else if ((r_state == ST_COMMIT) && (bus.alu_z != w_res_zero)) begin
      r_zmis <= 1'b1;
    end
  end

  assign z_mismatch = r_zmis;
`else
  logic w_unused_alu_z;
  assign w_unused_alu_z = bus.alu_z;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_alu_op_sequencer : randomized ops against a transaction-level  |
// |   model plus directed literal checks.                             |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module tb_alu_op_sequencer;

  localparam int SETTLE     = 1;
  localparam int MUL_SETTLE = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic tb_zbad = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_op_sequencer_if #(.W(16)) bus ();

`ifdef ZCHECK_EN
  logic z_mismatch;
`endif

  alu_op_sequencer #(
    .W          (16),
    .SETTLE     (SETTLE),
    .MUL_SETTLE (MUL_SETTLE)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
`ifdef ZCHECK_EN
    .z_mismatch (z_mismatch),
`endif
    .bus        (bus)
  );

  function automatic logic [15:0] alu_fn(input logic [3:0] cs, input logic [15:0] a, input logic [15:0] r);
    logic [31:0] p;
    p = {16'd0, a} * {16'd0, r};
    case (cs)
      4'h0: return a;
      4'h1: return a + r;
      4'h2: return a - r;
      4'h3: return ~a;
      4'h4: return a & r;
      4'h5: return a | r;
      4'h6: return a ^ r;
      4'h7: return p[15:0];
      4'h8: return a >> 1;
      4'h9: return a >> 2;
      4'hA: return r;
      default: return 16'h0000;
    endcase
  endfunction

  // Stand-in combinational ALU
  assign bus.alu_acout = alu_fn(bus.alu_cs, bus.alu_acin, bus.alu_rin);
  assign bus.alu_z     = tb_zbad ? 1'b0 : (bus.alu_acout == 16'h0000);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: an accepted legal op commits settle+1 edges later.
  logic [15:0] m_ac, m_pend, m_rin, m_cnt;
  logic [3:0]  m_code;
  logic        m_z, m_done, m_ill;
  int          m_left;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ac = 0; m_pend = 0; m_rin = 0; m_cnt = 0; m_code = 0;
      m_z = 0; m_done = 0; m_ill = 0; m_left = 0;
    end else begin
      m_done = 0;
      m_ill  = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_ac   = m_pend;
          m_z    = (m_pend == 16'h0000);
          m_cnt  = m_cnt + 16'd1;
          m_done = 1;
        end
      end else if (bus.op_valid) begin
        m_rin = bus.op_operand;
        if (bus.op_code >= 4'hC) begin
          m_done = 1;
          m_ill  = 1;
        end else begin
          m_code = bus.op_code;
          m_pend = alu_fn(bus.op_code, m_ac, bus.op_operand);
          m_left = ((bus.op_code == 4'h7) ? MUL_SETTLE : SETTLE) + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      chk("op_ready", {31'd0, bus.op_ready}, {31'd0, (m_left == 0)});
      chk("done",     {31'd0, bus.done},     {31'd0, m_done});
      chk("illegal",  {31'd0, bus.illegal},  {31'd0, m_ill});
      chk("ac_q",     {16'd0, bus.ac_q},     {16'd0, m_ac});
      chk("z_q",      {31'd0, bus.z_q},      {31'd0, m_z});
      chk("op_count", {16'd0, bus.op_count}, {16'd0, m_cnt});
      chk("alu_acin", {16'd0, bus.alu_acin}, {16'd0, m_ac});
      chk("alu_cs",   {28'd0, bus.alu_cs},   {28'd0, (m_left > 0) ? m_code : 4'h0});
      if (m_left > 0) chk("alu_rin", {16'd0, bus.alu_rin}, {16'd0, m_rin});
    end
  end

  // Presents an op and returns just after the accepting edge.
  task automatic do_op(input logic [3:0] c, input logic [15:0] d, input bit hold);
    int n;
    n = 0;
    @(negedge clk);
    bus.op_valid   = 1'b1;
    bus.op_code    = c;
    bus.op_operand = d;
    while (!bus.op_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      errors++;
      $display("FAIL accept_timeout: got no op_ready expected op_ready within 50 cycles");
    end
    @(posedge clk);
    #1;
    if (!hold) bus.op_valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.done && cyc < 50);
    if (!bus.done) begin
      errors++;
      $display("FAIL done_timeout: got no done expected done within 50 cycles");
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [3:0]  c;
    logic [15:0] d;
    bus.op_valid = 0; bus.op_code = 0; bus.op_operand = 0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_ac",    {16'd0, bus.ac_q}, 32'h0);
    chk("rst_ready", {31'd0, bus.op_ready}, 32'h1);
    chk("rst_count", {16'd0, bus.op_count}, 32'h0);
    chk("rst_cs",    {28'd0, bus.alu_cs}, 32'h0);
`ifdef ZCHECK_EN
    chk("rst_zmis",  {31'd0, z_mismatch}, 32'h0);
`endif

    do_op(4'h1, 16'h0005, 0); wait_done(cyc);
    chk("add_lat",  cyc, SETTLE + 2);
    chk("add1_ac",  {16'd0, bus.ac_q}, 32'h0005);
    chk("model_ac", {16'd0, m_ac}, 32'h0005);
    do_op(4'h1, 16'h0003, 0); wait_done(cyc);
    chk("add2_ac",  {16'd0, bus.ac_q}, 32'h0008);
    chk("add2_z",   {31'd0, bus.z_q}, 32'h0);
    chk("add2_cnt", {16'd0, bus.op_count}, 32'h0002);

    do_op(4'h2, 16'h0008, 0); wait_done(cyc);
    chk("sub0_ac", {16'd0, bus.ac_q}, 32'h0000);
    chk("sub0_z",  {31'd0, bus.z_q}, 32'h1);
    do_op(4'h2, 16'h0001, 0); wait_done(cyc);
    chk("subw_ac", {16'd0, bus.ac_q}, 32'hFFFF);
    chk("subw_z",  {31'd0, bus.z_q}, 32'h0);

    do_op(4'hA, 16'h0100, 0); wait_done(cyc);
    do_op(4'h7, 16'h0101, 1); wait_done(cyc);
    bus.op_valid = 1'b0;
    chk("mul_lat",  cyc, MUL_SETTLE + 2);
    chk("mul_ac",   {16'd0, bus.ac_q}, 32'h0100);
    chk("mul_cnt",  {16'd0, bus.op_count}, 32'h0006);
    chk("model_cnt", {16'd0, m_cnt}, 32'h0006);

    do_op(4'hD, 16'h1234, 0);
    @(negedge clk);
    chk("ill_done", {31'd0, bus.done}, 32'h1);
    chk("ill_flag", {31'd0, bus.illegal}, 32'h1);
    chk("ill_ac",   {16'd0, bus.ac_q}, 32'h0100);
    chk("ill_cnt",  {16'd0, bus.op_count}, 32'h0006);

    do_op(4'hA, 16'hBEEF, 0);
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("abort_done", {31'd0, bus.done}, 32'h0);
    end
    chk("abort_ac",    {16'd0, bus.ac_q}, 32'h0);
    chk("abort_ready", {31'd0, bus.op_ready}, 32'h1);
    chk("abort_cnt",   {16'd0, bus.op_count}, 32'h0);
    do_op(4'hB, 16'h5555, 0); wait_done(cyc);
    chk("clr_ac", {16'd0, bus.ac_q}, 32'h0);
    chk("clr_z",  {31'd0, bus.z_q}, 32'h1);

    for (int i = 0; i < 300; i++) begin
      c = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(12, 15)) : 4'($urandom_range(0, 11));
      d = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      do_op(c, d, 0);
      if (c < 4'hC && $urandom_range(0, 1) == 1) wait_done(cyc);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (6) @(negedge clk);

`ifdef ZCHECK_EN
    tb_zbad = 1'b1;
    do_op(4'hB, 16'h0000, 0); wait_done(cyc);
    tb_zbad = 1'b0;
    chk("zmis_set", {31'd0, z_mismatch}, 32'h1);
    do_op(4'h1, 16'h0001, 0); wait_done(cyc);
    chk("zmis_sticky", {31'd0, z_mismatch}, 32'h1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
